// File: rtl/seq_booth_multiplier.sv
// Iterative radix-2 Booth signed multiplier: one recoding step per enabled clock.
// The last completed product is held on result while the next multiply runs.
module seq_booth_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 start,
  input  logic [WIDTH-1:0]     inputA,
  input  logic [WIDTH-1:0]     inputB,
  output logic [2*WIDTH-1:0]   result,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH:0]       m_d, m_q;
  logic [WIDTH:0]       a_d, a_q;
  logic [WIDTH-1:0]     q_d, q_q;
  logic                 qm1_d, qm1_q;
  logic [CW-1:0]        cnt_d, cnt_q;
  logic                 busy_d, busy_q;
  logic                 done_d, done_q;
  logic [2*WIDTH-1:0]   result_d, result_q;
  logic [WIDTH:0]       sum;

  // Handshake: start (level) loads operands on any enabled edge and wins over a
  // running multiply; busy is high while steps remain; done rises on the edge
  // that writes result and stays high until the next load.
  always_comb begin
    m_d      = m_q;
    a_d      = a_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    result_d = result_q;

    case ({q_q[0], qm1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase

    if (en) begin
      if (start) begin
        m_d    = {inputA[WIDTH-1], inputA};
        a_d    = '0;
        q_d    = inputB;
        qm1_d  = 1'b0;
        cnt_d  = '0;
        busy_d = 1'b1;
        done_d = 1'b0;
      end else if (busy_q) begin
        // Arithmetic shift of {A,Q,q_-1}; A has one guard bit so -2^(W-1) is safe.
        a_d   = {sum[WIDTH], sum[WIDTH:1]};
        q_d   = {sum[0], q_q[WIDTH-1:1]};
        qm1_d = q_q[0];
        cnt_d = cnt_q + CW'(1);
        if (cnt_d == CW'(WIDTH)) begin
          result_d = {a_d[WIDTH-1:0], q_d};
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q      <= '0;
      a_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      m_q      <= m_d;
      a_q      <= a_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Bench for seq_booth_multiplier: directed operand pairs with literal products,
// plus an arithmetic model checked against the outputs on every falling edge.
module tb_seq_booth_multiplier;

  logic        clk;
  logic        reset;
  logic        en;
  logic        start;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic [63:0] result;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  seq_booth_multiplier #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .en     (en),
    .start  (start),
    .inputA (inputA),
    .inputB (inputB),
    .result (result),
    .busy   (busy),
    .done   (done)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: captured operands, count of enabled steps, plain product.
  int          m_a, m_b, m_steps;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [63:0] m_result = '0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_result = '0;
      m_steps  = 0;
    end else if (en) begin
      if (start) begin
        m_a     = int'(inputA);
        m_b     = int'(inputB);
        m_busy  = 1'b1;
        m_done  = 1'b0;
        m_steps = 0;
      end else if (m_busy) begin
        m_steps = m_steps + 1;
        if (m_steps == 32) begin
          m_result = 64'(longint'(m_a) * longint'(m_b));
          m_busy   = 1'b0;
          m_done   = 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    check("model_result", result, m_result);
    check("model_busy", {63'b0, busy}, {63'b0, m_busy});
    check("model_done", {63'b0, done}, {63'b0, m_done});
  end

  // Driver tasks
  task automatic load_hold(input logic [31:0] a, input logic [31:0] b, input int n);
    @(negedge clk);
    #1;
    start  = 1'b1;
    inputA = a;
    inputB = b;
    repeat (n) @(posedge clk);
    #1;
    start  = 1'b0;
    inputA = $urandom;
    inputB = $urandom;
  endtask

  task automatic wait_done(input int exp_lat, input logic [63:0] hold,
                           input logic [63:0] exp, input string name);
    int  n = 0;
    bit  seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      check({name, "_hold"}, result, hold);
    end
    check({name, "_seen"}, {63'b0, seen}, 64'd1);
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_product"}, result, exp);
    check({name, "_busy_low"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin
    reset  = 1'b1;
    en     = 1'b1;
    start  = 1'b0;
    inputA = '0;
    inputB = '0;
    #2 reset = 1'b0;
    #1;
    check("reset_result", result, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_busy", {63'b0, busy}, 64'd0);
    @(negedge clk);
    #1 reset = 1'b1;

    // Basic positive
    load_hold(32'd2, 32'd5, 1);
    wait_done(32, 64'd0, 64'd10, "p2x5");
    load_hold(32'd5, 32'd5, 1);
    wait_done(32, 64'd10, 64'd25, "p5x5");

    // Mixed signs
    load_hold(32'd4, -32'sd3, 1);
    wait_done(32, 64'd25, 64'hFFFF_FFFF_FFFF_FFF4, "p4xm3");
    load_hold(-32'sd7, 32'd6, 1);
    wait_done(32, 64'hFFFF_FFFF_FFFF_FFF4, 64'hFFFF_FFFF_FFFF_FFD6, "pm7x6");
    load_hold(-32'sd7, -32'sd2, 1);
    wait_done(32, 64'hFFFF_FFFF_FFFF_FFD6, 64'd14, "pm7xm2");

    // Back-to-back with start held 12 cycles
    load_hold(32'd1, 32'd6, 12);
    wait_done(32, 64'd14, 64'd6, "seq1x6");
    load_hold(32'd1, 32'd8, 12);
    wait_done(32, 64'd6, 64'd8, "seq1x8");
    load_hold(32'd3, 32'd7, 12);
    wait_done(32, 64'd8, 64'd21, "seq3x7");
    load_hold(32'd3, 32'd0, 12);
    wait_done(32, 64'd21, 64'd0, "seq3x0");

    // Extremes
    load_hold(32'h8000_0000, 32'h8000_0000, 1);
    wait_done(32, 64'd0, 64'h4000_0000_0000_0000, "min_x_min");
    load_hold(32'h7FFF_FFFF, 32'h8000_0000, 1);
    wait_done(32, 64'h4000_0000_0000_0000, 64'hC000_0000_8000_0000, "max_x_min");
    load_hold(32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done(32, 64'hC000_0000_8000_0000, 64'h0000_0000_8000_0000, "min_x_m1");
    repeat (5) begin
      @(posedge clk);
      #1;
      check("idle_hold_result", result, 64'h0000_0000_8000_0000);
      check("idle_hold_done", {63'b0, done}, 64'd1);
    end

    // Enable stall for 10 cycles mid-multiply
    load_hold(-32'sd7, 32'd6, 1);
    repeat (10) @(posedge clk);
    #1 en = 1'b0;
    repeat (10) @(posedge clk);
    #1 en = 1'b1;
    wait_done(22, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFD6, "en_stall");

    // Restart at step 15 with new operands
    load_hold(32'd100, 32'd200, 1);
    repeat (15) @(posedge clk);
    #1;
    check("restart_old_hold", result, 64'hFFFF_FFFF_FFFF_FFD6);
    start  = 1'b1;
    inputA = -32'sd9;
    inputB = 32'd11;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(32, 64'hFFFF_FFFF_FFFF_FFD6, 64'hFFFF_FFFF_FFFF_FF9D, "restart");

    // Async reset at step 20
    load_hold(32'd5, 32'd6, 1);
    repeat (20) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("areset_result", result, 64'd0);
    check("areset_busy", {63'b0, busy}, 64'd0);
    check("areset_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
      check("post_reset_done", {63'b0, done}, 64'd0);
      check("post_reset_busy", {63'b0, busy}, 64'd0);
      check("post_reset_result", result, 64'd0);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_booth_multiplier.md
Name: seq_booth_multiplier

Overview:
- Iterative signed multiplier: 32-bit two's-complement operands, full 64-bit signed product.
- Uses radix-2 Booth recoding, one step per enabled clock, so one multiply takes 32 cycles after loading.
- Used where area matters more than throughput.
- The last product stays on the output while the next multiply runs.

Parameters:
- WIDTH, 32, operand width in bits; the product is 2*WIDTH bits; the step counter is clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  clock enable; when low, all state is frozen.
- start  input  1  level-sensitive load/restart request, sampled on enabled rising edges.
- inputA  input  WIDTH  signed multiplicand.
- inputB  input  WIDTH  signed multiplier.
- result  output  2*WIDTH  signed product, registered.
- busy  output  1  high while Booth steps are in progress.
- done  output  1  high once result holds the product of the last loaded operands.

Behaviour:
- Reset (reset=0, asynchronous, no clock needed):
  - result=0, busy=0, done=0, counter=0, internal accumulator/shift registers=0.
  - Holds while reset is low; start and en are ignored.
- en=0 at a rising edge: no register changes, including during computation.
- Load (enabled edge with start=1):
  - capture inputA as the multiplicand M, sign-extended to WIDTH+1 bits;
  - set the register {A=0 (WIDTH+1 bits), Q=inputB, q_-1=0};
  - counter=0, busy=1, done=0; result unchanged.
  - Start held high reloads every enabled edge. Start=1 while busy aborts and restarts; no partial result is ever written.
- Step (enabled edge, start=0, busy=1), Booth radix-2 on {Q[0], q_-1}:
  - 01: A=A+M.
  - 10: A=A-M.
  - 00/11: A unchanged.
  - Then arithmetic-shift {A,Q,q_-1} right by 1 and counter=counter+1.
  - A is WIDTH+1 bits, so -2^31 operands do not overflow.
- Completion:
  - On the enabled edge performing step WIDTH (counter reaches WIDTH): result = low 2*WIDTH bits of {A,Q} after the shift, busy=0, done=1.
  - Latency: the product is visible after WIDTH enabled edges following the last start-high edge.
- Idle (busy=0, start=0):
  - result and done hold indefinitely; result stays stable until the next completion.
- Arithmetic: result equals the exact signed product inputA*inputB for all operand pairs, including:
  - (-2^31)*(-2^31) = 2^62;
  - (-2^31)*(-1) = 2^31;
  - x*0 = 0.
- Operand inputs may change freely after the load edge; only the captured values are used.
- Reset mid-operation aborts immediately; result is forced to 0.

Test Plan:
- Reset then basic positive:
  - Pulse reset low: result=0, done=0.
  - Load A=2, B=5, drop start: busy for 32 edges, then result=10, done=1.
  - A=5, B=5 -> 25.
- Mixed signs:
  - A=4, B=-3 -> -12 (0xFFFF_FFFF_FFFF_FFF4).
  - A=-7, B=6 -> -42.
  - A=-7, B=-2 -> 14.
- Sequence and hold:
  - Back-to-back loads (1,6), (1,8), (3,7), (3,0) with start held 12 cycles each.
  - Results 6, 8, 21, 0.
  - While each new multiply runs, result still shows the previous product.
- Extremes:
  - (-2^31)*(-2^31) -> 0x4000_0000_0000_0000.
  - (2^31-1)*(-2^31) -> -(2^62-2^31).
  - (-2^31)*(-1) -> 2^31.
- Enable/restart:
  - Deassert en for 10 cycles mid-multiply: completion delayed exactly 10 cycles, product still correct.
  - Assert start at step 15 with new operands: old multiply abandoned, result unchanged until the new product appears 32 enabled edges after start falls.
- Async reset mid-multiply:
  - Assert reset between clock edges at step 20: result=0, busy=0, done=0 immediately.
  - After release, no completion occurs without a new start.
